// File: rtl/isp_frame_feeder.sv
// isp_frame_feeder
//   Front end of the ISP pipeline. Buffers raw 8-bit Bayer pixels arriving
//   from the sensor over a valid/ready handshake. Replays them to the pipeline
//   as a framed stream, in this order:
//     1. a oNewFrame pulse;
//     2. a pre-frame idle gap;
//     3. 'height' contiguous rows of 'width' valid pixels, each row followed
//        by hBlank idle cycles;
//     4. zero-data flush rows (each also followed by hBlank idle cycles)
//        until the pipeline reports done or maxFlushRows have been sent.
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   iStart         begin a frame (only honoured in IDLE)
//   iSensorValid   sensor pixel valid
//   iSensorData    sensor pixel
//   oSensorReady   a pixel is accepted this cycle if iSensorValid is high
//   iPipeDone      pipeline done level, looked at on the last flush cycle
//   oNewFrame      one-cycle frame start pulse
//   oValid/oData   pipeline pixel stream (registered)
//   oBusy          high whenever the FSM is not in IDLE
//   oFlushTimeout  sticky; the flush-row budget ran out without iPipeDone
module isp_frame_feeder #(
    parameter int width        = 320,
    parameter int height       = 240,
    parameter int hBlank       = 16,
    parameter int preFrameGap  = 32,
    parameter int fifoDepth    = 512,
    parameter int maxFlushRows = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iStart,
    input  logic       iSensorValid,
    input  logic [7:0] iSensorData,
    output logic       oSensorReady,
    input  logic       iPipeDone,
    output logic       oNewFrame,
    output logic       oValid,
    output logic [7:0] oData,
    output logic       oBusy,
    output logic       oFlushTimeout
);
    localparam int PIX  = width * height;
    localparam int AW   = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
    localparam int CW   = (width > 1) ? $clog2(width) : 1;
    localparam int RW   = $clog2(height + 1);
    localparam int FW   = $clog2(maxFlushRows + 1);
    localparam int GMAX = (preFrameGap > hBlank) ? preFrameGap : hBlank;
    localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;
    localparam int ACW  = $clog2(PIX + 1);

    localparam logic [AW:0]    W_CNT    = (AW+1)'(width);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(fifoDepth);
    localparam logic [CW-1:0]  COL_LAST = CW'(width - 1);
    localparam logic [RW-1:0]  ROWS     = RW'(height);
    localparam logic [FW-1:0]  FLUSHES  = FW'(maxFlushRows);
    localparam logic [GW-1:0]  PRE_LAST = GW'(preFrameGap - 1);
    localparam logic [GW-1:0]  HB_LAST  = GW'(hBlank - 1);
    localparam logic [ACW-1:0] PIX_CNT  = ACW'(PIX);

    typedef enum logic [3:0] {
        IDLE, NEWF, PREGAP, WAITROW, ROW, HBLANK, FLUSH, FBLANK, DONE
    } state_t;

    state_t state, state_nx;

    logic [7:0]     mem [fifoDepth];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count, cnt_next;
    logic [ACW-1:0] accepted;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [FW-1:0]  flush;
    logic [GW-1:0]  gap;
    logic           push, pop, full, col_last, row_go;

    assign full         = (count == FULL_CNT);
    assign oSensorReady = (state != IDLE) && !full && (accepted < PIX_CNT);
    assign push         = iSensorValid && oSensorReady;
    // ROW is only ever entered with a full row buffered, so this never underflows.
    assign pop          = (state == ROW);
    assign col_last     = (col == COL_LAST);
    assign oBusy        = (state != IDLE);

    always_comb begin
        cnt_next = count;
        case ({push, pop})
            2'b10:   cnt_next = count + 1'b1;
            2'b01:   cnt_next = count - 1'b1;
            default: cnt_next = count;
        endcase
    end

    // Look at the post-edge occupancy so a row can start straight out of a
    // gap on the same edge that writes its last pixel, with no extra idle cycle.
    assign row_go = (cnt_next >= W_CNT);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (iStart) state_nx = NEWF;
            NEWF:    state_nx = PREGAP;
            PREGAP:  if (gap == PRE_LAST) state_nx = row_go ? ROW : WAITROW;
            WAITROW: if (row_go) state_nx = ROW;
            ROW:     if (col_last) state_nx = HBLANK;
            HBLANK:  if (gap == HB_LAST)
                         state_nx = (row == ROWS) ? FLUSH : (row_go ? ROW : WAITROW);
            FLUSH:   if (col_last) state_nx = iPipeDone ? DONE : FBLANK;
            FBLANK:  if (gap == HB_LAST) state_nx = (flush == FLUSHES) ? DONE : FLUSH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= iSensorData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            accepted      <= '0;
            col           <= '0;
            row           <= '0;
            flush         <= '0;
            gap           <= '0;
            oNewFrame     <= 1'b0;
            oValid        <= 1'b0;
            oData         <= '0;
            oFlushTimeout <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= cnt_next;
            accepted <= (state == IDLE) ? '0 : accepted + ACW'(push);

            case (state)
                NEWF: begin
                    col   <= '0;
                    row   <= '0;
                    flush <= '0;
                    gap   <= '0;
                end
                // gap restarts from zero whenever one of the idle states is left
                PREGAP, HBLANK, FBLANK: gap <= (state_nx == state) ? gap + 1'b1 : '0;
                ROW: begin
                    col <= col_last ? '0 : col + 1'b1;
                    if (col_last) row <= row + 1'b1;
                end
                FLUSH: begin
                    col <= col_last ? '0 : col + 1'b1;
                    if (col_last) flush <= flush + 1'b1;
                end
                default: ;
            endcase

            if (state == IDLE && iStart)
                oFlushTimeout <= 1'b0;
            else if (state == FBLANK && gap == HB_LAST && flush == FLUSHES)
                oFlushTimeout <= 1'b1;

            oNewFrame <= (state == NEWF);
            oValid    <= (state == ROW) || (state == FLUSH);
            oData     <= pop ? mem[rd_ptr] : '0;
        end
    end
endmodule

// File: tb/tb_isp_frame_feeder.sv
// Bench for isp_frame_feeder with a 4x3 frame, hBlank=2, preFrameGap=3,
// fifoDepth=8 and maxFlushRows=2. Expected pixels are queued when a frame is
// set up. A negedge monitor pops the queue on every oValid cycle and records
// the cycle number, so that row and gap timing can be checked afterwards.
module tb_isp_frame_feeder;
    localparam int W = 4, H = 3, HB = 2, PG = 3, FD = 8, MF = 2;

    logic       clk = 0, reset = 0, iStart = 0, iSensorValid = 0, iPipeDone = 0;
    logic [7:0] iSensorData = '0;
    logic       oSensorReady, oNewFrame, oValid, oBusy, oFlushTimeout;
    logic [7:0] oData;

    int         cyc = 0, errs = 0, checks = 0;
    logic [7:0] exp_q[$];
    int         vt_q[$];
    int         nf_cyc = -100, nf_n = 0, done_thr = 0, sent = 0, stall_left = 0, h4 = -100;
    bit         drv_en = 1;

    isp_frame_feeder #(
        .width(W), .height(H), .hBlank(HB), .preFrameGap(PG),
        .fifoDepth(FD), .maxFlushRows(MF)
    ) dut (
        .clk(clk), .reset(reset), .iStart(iStart),
        .iSensorValid(iSensorValid), .iSensorData(iSensorData),
        .oSensorReady(oSensorReady), .iPipeDone(iPipeDone),
        .oNewFrame(oNewFrame), .oValid(oValid), .oData(oData),
        .oBusy(oBusy), .oFlushTimeout(oFlushTimeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard pop plus timing log; also drives iPipeDone from the
    // number of valid cycles seen so far.
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset) begin
            if (oNewFrame) begin
                nf_cyc = cyc;
                nf_n++;
            end
            if (oValid) begin
                vt_q.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL extra_valid: oData=%0d with no expected pixel", oData);
                end else begin
                    e = exp_q.pop_front();
                    if (oData !== e) begin
                        errs++;
                        $display("FAIL odata: got %0d expected %0d", oData, e);
                    end
                end
            end
        end
        iPipeDone = (vt_q.size() >= done_thr);
    end

    // Sensor: pixel n+1 always offered; optional stall after the 3rd pixel.
    initial begin
        forever begin
            @(negedge clk);
            if (drv_en) begin
                if (sent == 3 && stall_left > 0) begin
                    iSensorValid = 0;
                    stall_left--;
                end else begin
                    iSensorValid = 1;
                    iSensorData  = 8'(sent + 1);
                end
            end else iSensorValid = 0;
            if (iSensorValid && oSensorReady) begin
                sent++;
                if (sent == 4) h4 = cyc + 1;
            end
        end
    end

    task automatic setup(input int zrows, input int thr, input int stall);
        exp_q.delete();
        vt_q.delete();
        nf_n = 0; nf_cyc = -100; sent = 0; h4 = -100;
        stall_left = stall;
        done_thr = thr;
        for (int p = 1; p <= W*H; p++) exp_q.push_back(8'(p));
        for (int z = 0; z < zrows*W; z++) exp_q.push_back(8'd0);
    endtask

    task automatic pulse();
        iStart = 1;
        @(negedge clk);
        iStart = 0;
    endtask

    task automatic wait_idle(input string tag, input bit restart);
        int bud = 0;
        while (oBusy && bud < 400) begin
            @(negedge clk);
            bud++;
            iStart = restart && (bud == 10);
        end
        iStart = 0;
        @(negedge clk);
        chk({tag, "_idle"}, oBusy, 0);
    endtask

    task automatic check_frame(input string tag, input int zrows, input bit stalled, input bit expto);
        int bad = 0;
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_nvalid"}, vt_q.size(), W*H + W*zrows);
        chk({tag, "_newframe"}, nf_n, 1);
        chk({tag, "_accepted"}, sent, W*H);
        chk({tag, "_timeout"}, oFlushTimeout, expto);
        if (vt_q.size() == W*H + W*zrows) begin
            chk({tag, "_pregap"}, vt_q[0] - nf_cyc, stalled ? 24 : PG + 1);
            chk({tag, "_row_after_px4"}, vt_q[0] - h4, 1);
            for (int r = 0; r < H + zrows; r++) begin
                for (int i = 1; i < W; i++)
                    if (vt_q[W*r+i] - vt_q[W*r] != i) bad++;
                if (r > 0 && vt_q[W*r] - vt_q[W*r-1] != HB + 1) bad++;
            end
            chk({tag, "_row_timing"}, bad, 0);
        end
    endtask

    task automatic std_frame(input string tag, input bit restart);
        setup(1, 0, 0);
        pulse();
        wait_idle(tag, restart);
        check_frame(tag, 1, 0, 0);
    endtask

    initial begin
        int bud;
        repeat (2) @(negedge clk);
        chk("rst_ready", oSensorReady, 0);
        chk("rst_newframe", oNewFrame, 0);
        chk("rst_valid", oValid, 0);
        chk("rst_data", oData, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_timeout", oFlushTimeout, 0);
        reset = 1;
        @(negedge clk);

        // continuous stream, pipeline done on the first flush row
        std_frame("stream", 0);

        // stall 20 cycles after pixel 3
        setup(1, 0, 20);
        pulse();
        wait_idle("stall", 0);
        check_frame("stall", 1, 1, 0);

        // done raised during the second flush row
        setup(2, W*H + W + 1, 0);
        pulse();
        wait_idle("done2", 0);
        check_frame("done2", 2, 0, 0);

        // done never comes: two flush rows then timeout
        setup(2, 1000, 0);
        pulse();
        wait_idle("tmo", 0);
        check_frame("tmo", 2, 0, 1);

        // timeout flag clears on the next start
        setup(1, 0, 0);
        pulse();
        chk("tmo_clear", oFlushTimeout, 0);
        wait_idle("after_tmo", 0);
        check_frame("after_tmo", 1, 0, 0);

        // asynchronous reset in the middle of row 2
        setup(1, 0, 0);
        pulse();
        bud = 0;
        while (vt_q.size() < W + 2 && bud < 200) begin
            @(negedge clk);
            bud++;
        end
        chk("mid_reached_row2", oValid, 1);
        #2 reset = 0;
        #1;
        chk("mid_valid", oValid, 0);
        chk("mid_data", oData, 0);
        chk("mid_busy", oBusy, 0);
        chk("mid_ready", oSensorReady, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        std_frame("post_rst", 0);

        // iStart while busy is ignored
        std_frame("restart", 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
